tqvp_alonso_rsa_ctrl: RTL and testbench
=======================================

TQVP_ALONSO_RSA_CTRL -- requirements
Module: tqvp_alonso_rsa_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits for M, E, N and the result.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ui_in  in  8  input PMOD; unused, ignored.
REQ-005 uo_out  out  8  status pins {5'b0, err, done, busy}.
REQ-006 address  in  4  register select.
REQ-007 data_write  in  1  write strobe; data_in is valid while high.
REQ-008 data_in  in  8  write data.
REQ-009 data_out  out  8  read data, combinational from address.

Function
REQ-010 Register map: 0x0 M (rw), 0x1 E (rw), 0x2 N (rw), 0x3 CTRL (write bit0=1 -> start), 0x4 STATUS {5'b0, err, done, busy} (ro), 0x5 RESULT (ro); other addresses read 0 and ignore writes.
REQ-011 Computes RESULT = M^E mod N by left-to-right square-and-multiply over all WIDTH bits of E, MSB first, with R initialised to 1.
REQ-012 FSM states: IDLE, SQR, SQR_WAIT, MUL, MUL_WAIT, NEXT, DONE.
REQ-013 IDLE -> SQR on an accepted start; bit index = WIDTH-1; R = 1; busy rises the cycle after the start write.
REQ-014 SQR: mul_start high for one cycle with a = b = R -> SQR_WAIT.
REQ-015 SQR_WAIT: on mul_done, R = product; -> MUL if E[index] = 1, else -> NEXT.
REQ-016 MUL: mul_start high for one cycle with a = R, b = M -> MUL_WAIT; on mul_done, R = product -> NEXT.
REQ-017 NEXT: if index = 0 -> DONE; else index decrements -> SQR.
REQ-018 DONE: RESULT = R, done = 1, busy = 0 -> IDLE, all in one cycle.
REQ-019 Modular multiplier: mul_done pulses exactly WIDTH+1 cycles after the mul_start cycle, and the product is valid in that same cycle.
REQ-020 Busy duration: exactly WIDTH*(WIDTH+3) + popcount(E)*(WIDTH+2) cycles, i.e. 88 + 10*popcount(E) for WIDTH = 8.
REQ-021 Start validation, applied in the start cycle:
- If N < 2 or M >= N: err = 1, done = 1, RESULT = 0, no computation, FSM stays in IDLE.
- Otherwise err clears.
REQ-022 done clears on an accepted start and is otherwise sticky; err is sticky until the next accepted start.
REQ-023 While busy = 1: writes to M, E, N and CTRL are ignored; M, E, N hold their values.
REQ-024 E = 0 yields RESULT = 1 with the standard latency from REQ-020.
REQ-025 Multiplier internal width is WIDTH+1 bits; each step does at most one conditional subtract of N; all values stay below N.

Reset
REQ-026 rst applies in any state, including mid-operation, and forces on the next edge:
- FSM to IDLE; M, E, N, RESULT, R and bit index to 0;
- busy, done, err and mul_start to 0;
- multiplier to idle;
- uo_out and the STATUS read to 0.

Structure
REQ-027 A shared package holds the FSM state enum, the register address constants (0x0-0x5) and the STATUS bit positions.
REQ-028 One sub-module, tqvp_alonso_rsa_modmul, implements the interleaved shift-add modular multiplier:
- ports clk, rst, mul_start, a, b, n, product, mul_done;
- one bit of b per cycle, MSB first: P = 2P mod n, then P = P + a mod n if the bit is set.

Verification
REQ-029 M=5, E=3, N=13, start -> RESULT=8, done=1, busy high exactly 108 cycles.
REQ-030 M=254, E=255, N=255 -> RESULT=254, busy exactly 168 cycles.
REQ-031 M=7, E=0, N=11 -> RESULT=1, busy exactly 88 cycles.
REQ-032 N=1 or M=20 with N=13, start -> err=1, done=1, RESULT=0, busy never rises.
REQ-033 Mid-run write M=9 plus a second start -> ignored, original RESULT correct; rst asserted mid-run -> all outputs 0 next cycle, and a fresh start then completes correctly.

Source files
------------

// File: rtl/tqvp_alonso_rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation peripheral:
// controller state encoding, register addresses and STATUS bit positions.
package tqvp_alonso_rsa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SQR      = 3'd1,
        ST_SQR_WAIT = 3'd2,
        ST_MUL      = 3'd3,
        ST_MUL_WAIT = 3'd4,
        ST_NEXT     = 3'd5,
        ST_DONE     = 3'd6
    } rsa_state_e;

    localparam logic [3:0] ADDR_M      = 4'h0;
    localparam logic [3:0] ADDR_E      = 4'h1;
    localparam logic [3:0] ADDR_N      = 4'h2;
    localparam logic [3:0] ADDR_CTRL   = 4'h3;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_RESULT = 4'h5;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

endpackage

// File: rtl/tqvp_alonso_rsa_modmul.sv
// Interleaved shift-add modular multiplier: product = a*b mod n, one bit of b
// per cycle, MSB first; mul_done pulses WIDTH+1 cycles after the mul_start cycle.
module tqvp_alonso_rsa_modmul #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mul_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] product,
    output logic             mul_done
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             running;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q, n_q, p;
    logic [WIDTH:0]   dbl, dbl_r, sum, sum_r, step;

    // Operands are kept below n, so each partial result needs only one subtract.
    always_comb begin
        dbl   = {p, 1'b0};
        dbl_r = (dbl >= {1'b0, n_q}) ? dbl - {1'b0, n_q} : dbl;
        sum   = dbl_r + {1'b0, a_q};
        sum_r = (sum >= {1'b0, n_q}) ? sum - {1'b0, n_q} : sum;
        step  = b_q[WIDTH-1] ? sum_r : dbl_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running  <= 1'b0;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            p        <= '0;
            mul_done <= 1'b0;
        end else begin
            mul_done <= 1'b0;
            if (mul_start) begin
                running <= 1'b1;
                cnt     <= CW'(WIDTH);
                a_q     <= a;
                b_q     <= b;
                n_q     <= n;
                p       <= '0;
            end else if (running) begin
                p   <= step[WIDTH-1:0];
                b_q <= b_q << 1;
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    running  <= 1'b0;
                    mul_done <= 1'b1;
                end
            end
        end
    end

    assign product = p;

endmodule

// File: rtl/tqvp_alonso_rsa_ctrl.sv
// Register-mapped RSA peripheral: RESULT = M^E mod N by left-to-right
// square-and-multiply over all WIDTH exponent bits.
module tqvp_alonso_rsa_ctrl
    import tqvp_alonso_rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    rsa_state_e       state;
    logic [WIDTH-1:0] m, e, n, r, result;
    logic [IW-1:0]    idx;
    logic             busy, done, err;
    logic             mul_start, mul_done;
    logic [WIDTH-1:0] mul_b, product;
    logic [7:0]       status;
    logic             unused_ui;

    assign unused_ui = ^ui_in;

    assign mul_start = (state == ST_SQR) || (state == ST_MUL);
    assign mul_b     = (state == ST_MUL) ? m : r;

    tqvp_alonso_rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
        .clk       (clk),
        .rst       (rst),
        .mul_start (mul_start),
        .a         (r),
        .b         (mul_b),
        .n         (n),
        .product   (product),
        .mul_done  (mul_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            m      <= '0;
            e      <= '0;
            n      <= '0;
            r      <= '0;
            result <= '0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            // Operand registers are frozen for the whole computation.
            if (data_write && !busy) begin
                case (address)
                    ADDR_M:  m <= WIDTH'(data_in);
                    ADDR_E:  e <= WIDTH'(data_in);
                    ADDR_N:  n <= WIDTH'(data_in);
                    default: ;
                endcase
            end
            case (state)
                ST_IDLE: begin
                    if (data_write && address == ADDR_CTRL && data_in[0]) begin
                        if (n < WIDTH'(2) || m >= n) begin
                            err    <= 1'b1;
                            done   <= 1'b1;
                            result <= '0;
                        end else begin
                            err   <= 1'b0;
                            done  <= 1'b0;
                            busy  <= 1'b1;
                            r     <= WIDTH'(1);
                            idx   <= IW'(WIDTH - 1);
                            state <= ST_SQR;
                        end
                    end
                end
                ST_SQR: state <= ST_SQR_WAIT;
                ST_SQR_WAIT: begin
                    if (mul_done) begin
                        r     <= product;
                        state <= e[idx] ? ST_MUL : ST_NEXT;
                    end
                end
                ST_MUL: state <= ST_MUL_WAIT;
                ST_MUL_WAIT: begin
                    if (mul_done) begin
                        r     <= product;
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (idx == '0) begin
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx - 1'b1;
                        state <= ST_SQR;
                    end
                end
                ST_DONE: begin
                    result <= r;
                    done   <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        status            = '0;
        status[STAT_BUSY] = busy;
        status[STAT_DONE] = done;
        status[STAT_ERR]  = err;
    end

    assign uo_out = status;

    always_comb begin
        data_out = '0;
        case (address)
            ADDR_M:      data_out = 8'(m);
            ADDR_E:      data_out = 8'(e);
            ADDR_N:      data_out = 8'(n);
            ADDR_STATUS: data_out = status;
            ADDR_RESULT: data_out = 8'(result);
            default:     data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_tqvp_alonso_rsa_ctrl.sv
// Directed self-checking bench for tqvp_alonso_rsa_ctrl: result values,
// busy duration, validation errors, busy write lockout and mid-run reset.
module tb_tqvp_alonso_rsa_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  tqvp_alonso_rsa_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change on the falling edge
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address    = a;
    data_in    = d;
    data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    address = a;
    #1;
    d = data_out;
  endtask

  task automatic wait_done(input string tag, output int busy_cyc);
    bit seen = 1'b0;
    busy_cyc = 0;
    for (int c = 0; c < 2000; c++) begin
      if (uo_out[1]) begin
        seen = 1'b1;
        break;
      end
      if (uo_out[0]) busy_cyc++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic run(input string tag, input logic [7:0] mv, input logic [7:0] ev,
                     input logic [7:0] nv, input logic [7:0] exp_res, input int exp_busy);
    int busy_cyc;
    logic [7:0] d;
    wr(4'h0, mv);
    wr(4'h1, ev);
    wr(4'h2, nv);
    exp_q.push_back(exp_res);
    wr(4'h3, 8'h01);
    wait_done(tag, busy_cyc);
    check({tag, "_busy_cycles"}, busy_cyc, exp_busy);
    repeat (3) @(negedge clk);
    rd(4'h5, d);
    check({tag, "_result"}, d, exp_q.pop_front());
    rd(4'h4, d);
    check({tag, "_status"}, d, 8'h02);
  endtask

  task automatic run_err(input string tag, input logic [7:0] mv, input logic [7:0] nv);
    int busy_seen = 0;
    logic [7:0] d;
    wr(4'h0, mv);
    wr(4'h2, nv);
    wr(4'h3, 8'h01);
    for (int c = 0; c < 10; c++) begin
      if (uo_out[0]) busy_seen++;
      @(negedge clk);
    end
    check({tag, "_busy_seen"}, busy_seen, 0);
    check({tag, "_uo_out"}, uo_out, 8'h06);
    rd(4'h5, d);
    check({tag, "_result"}, d, 8'h00);
  endtask

  initial begin
    logic [7:0] d;
    int busy_cyc;
    rst        = 1'b1;
    ui_in      = 8'($urandom_range(0, 255));
    address    = 4'h0;
    data_write = 1'b0;
    data_in    = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_uo_out", uo_out, 8'h00);
    for (int a = 0; a < 6; a++) begin
      rd(4'(a), d);
      check($sformatf("reset_read_%0d", a), d, 8'h00);
    end
    rst = 1'b0;

    run("m5e3n13",      8'd5,   8'd3,   8'd13,  8'd8,   108);
    run("m254e255n255", 8'd254, 8'd255, 8'd255, 8'd254, 168);
    run("m7e0n11",      8'd7,   8'd0,   8'd11,  8'd1,   88);
    run("m3e5n7",       8'd3,   8'd5,   8'd7,   8'd5,   108);
    run("m2e8n251",     8'd2,   8'd8,   8'd251, 8'd5,   98);
    run("m0e5n9",       8'd0,   8'd5,   8'd9,   8'd0,   108);

    run_err("n_is_1",     8'd0,  8'd1);
    run_err("m20_n13",    8'd20, 8'd13);
    // a valid start clears the sticky error
    run("after_err",    8'd4,   8'd2,   8'd13,  8'd3,   98);

    // writes while busy are ignored, including a second start
    wr(4'h0, 8'd5);
    wr(4'h1, 8'd3);
    wr(4'h2, 8'd13);
    wr(4'h3, 8'h01);
    repeat (10) @(negedge clk);
    wr(4'h0, 8'd9);
    wr(4'h1, 8'd0);
    wr(4'h3, 8'h01);
    wait_done("busy_lock", busy_cyc);
    repeat (2) @(negedge clk);
    rd(4'h5, d);
    check("busy_lock_result", d, 8'd8);
    rd(4'h0, d);
    check("busy_lock_m", d, 8'd5);
    rd(4'h1, d);
    check("busy_lock_e", d, 8'd3);

    // reset in the middle of a computation
    wr(4'h0, 8'd6);
    wr(4'h1, 8'd7);
    wr(4'h2, 8'd11);
    wr(4'h3, 8'h01);
    repeat (20) @(negedge clk);
    check("midrst_busy_before", uo_out[0], 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_uo_out", uo_out, 8'h00);
    for (int a = 0; a < 6; a++) begin
      rd(4'(a), d);
      check($sformatf("midrst_read_%0d", a), d, 8'h00);
    end
    rst = 1'b0;
    run("after_rst",    8'd6,   8'd7,   8'd11,  8'd8,   118);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
